// File: rtl/bra_predict_ctrl_if.sv
// Bundle of the decoder lookup, ROB commit and predictor-table ports of the branch predictor controller.
// The slave modport is the controller's view; the master modport is the environment's view.
`ifndef Bra_History_Width
`define Bra_History_Width 2
`endif
`ifndef Bra_Addr_Width
`define Bra_Addr_Width 4
`endif

interface bra_predict_ctrl_if #(
  parameter int HIST_W = `Bra_History_Width,
  parameter int ADDR_W = `Bra_Addr_Width
);
  // Decoder lookup (always accepted, combinational answer)
  logic              dec_req;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_prediction;
  logic [HIST_W-1:0] dec_pattern;
  // ROB commit: a beat transfers on a rising edge where rob_valid && rob_ready;
  // rob_ready never depends on rob_valid, and an offered beat must hold until taken.
  logic              rob_valid;
  logic              rob_ready;
  logic [HIST_W-1:0] rob_pattern;
  logic [ADDR_W-1:0] rob_addr;
  logic              rob_taken;
  logic              rob_mispredict;
  // Predictor table
  logic [HIST_W-1:0] brp_pattern;
  logic [ADDR_W-1:0] brp_addr;
  logic              brp_prediction;
  logic              brp_update;
  logic [HIST_W-1:0] brp_upd_pattern;
  logic [ADDR_W-1:0] brp_upd_addr;
  logic              brp_upd_taken;
  // Status and debug visibility
  logic [15:0]       mispredict_cnt;
  logic [HIST_W-1:0] dbg_commit_ghr;
  logic [7:0]        dbg_fifo_cnt;

  modport slave (
    input  dec_req, dec_addr, rob_valid, rob_pattern, rob_addr, rob_taken,
           rob_mispredict, brp_prediction,
    output dec_prediction, dec_pattern, rob_ready, brp_pattern, brp_addr,
           brp_update, brp_upd_pattern, brp_upd_addr, brp_upd_taken,
           mispredict_cnt, dbg_commit_ghr, dbg_fifo_cnt
  );

  modport master (
    output dec_req, dec_addr, rob_valid, rob_pattern, rob_addr, rob_taken,
           rob_mispredict, brp_prediction,
    input  dec_prediction, dec_pattern, rob_ready, brp_pattern, brp_addr,
           brp_update, brp_upd_pattern, brp_upd_addr, brp_upd_taken,
           mispredict_cnt, dbg_commit_ghr, dbg_fifo_cnt
  );
endinterface

// File: rtl/bra_predict_ctrl.sv
// Branch predictor controller: speculative/committed GHR, update FIFO and
// single-port arbitration of the predictor table with lookup priority.
`ifndef Bra_History_Width
`define Bra_History_Width 2
`endif
`ifndef Bra_Addr_Width
`define Bra_Addr_Width 4
`endif

module bra_predict_ctrl #(
  parameter int HIST_W = `Bra_History_Width,
  parameter int ADDR_W = `Bra_Addr_Width,
  parameter int QDEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  bra_predict_ctrl_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int EW = HIST_W + ADDR_W + 1;

  logic [HIST_W-1:0] spec_ghr_q, spec_ghr_d;
  logic [HIST_W-1:0] commit_ghr_q, commit_ghr_d;
  logic [15:0]       mp_cnt_q, mp_cnt_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]     mem_q [QDEPTH];

  logic          empty, full, push, pop, mp_commit;
  logic [PW:0]   fifo_cnt;
  logic [EW-1:0] head;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                    (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign fifo_cnt = wr_ptr_q - rd_ptr_q;
  assign head     = mem_q[rd_ptr_q[PW-1:0]];

  assign bus.rob_ready = !full && !rst;
  assign push          = bus.rob_valid && bus.rob_ready;
  assign mp_commit     = push && bus.rob_mispredict;
  // Lookups own the table port; rst also blocks the strobe so nothing stale is written.
  assign pop           = !empty && !bus.dec_req && !rst;

  assign bus.brp_pattern     = spec_ghr_q;
  assign bus.brp_addr        = bus.dec_addr;
  assign bus.dec_prediction  = bus.brp_prediction;
  assign bus.dec_pattern     = spec_ghr_q;
  assign bus.brp_update      = pop;
  assign bus.brp_upd_pattern = head[EW-1 -: HIST_W];
  assign bus.brp_upd_addr    = head[ADDR_W:1];
  assign bus.brp_upd_taken   = head[0];
  assign bus.mispredict_cnt  = mp_cnt_q;
  assign bus.dbg_commit_ghr  = commit_ghr_q;
  assign bus.dbg_fifo_cnt    = 8'(fifo_cnt);

  always_comb begin
    spec_ghr_d   = spec_ghr_q;
    commit_ghr_d = commit_ghr_q;
    mp_cnt_d     = mp_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    // Repair wins over the lookup shift; the decoder flushes that lookup anyway.
    if (mp_commit) begin
      spec_ghr_d = {commit_ghr_q[HIST_W-2:0], bus.rob_taken};
    end else if (bus.dec_req) begin
      spec_ghr_d = {spec_ghr_q[HIST_W-2:0], bus.brp_prediction};
    end
    if (push) begin
      commit_ghr_d = {commit_ghr_q[HIST_W-2:0], bus.rob_taken};
      wr_ptr_d     = wr_ptr_q + 1'b1;
    end
    if (mp_commit && (mp_cnt_q != 16'hFFFF)) begin
      mp_cnt_d = mp_cnt_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
      mp_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      spec_ghr_q   <= spec_ghr_d;
      commit_ghr_q <= commit_ghr_d;
      mp_cnt_q     <= mp_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= {bus.rob_pattern, bus.rob_addr, bus.rob_taken};
    end
  end
endmodule

// File: tb/tb_bra_predict_ctrl.sv
// Directed bench for bra_predict_ctrl (HIST_W=2, ADDR_W=4, QDEPTH=4) with
// hand-computed expectations checked by immediate assertions.
module tb_bra_predict_ctrl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bra_predict_ctrl_if #(.HIST_W(2), .ADDR_W(4)) bus ();

  bra_predict_ctrl #(.HIST_W(2), .ADDR_W(4), .QDEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.dec_req        = 1'b0;
    bus.dec_addr       = '0;
    bus.brp_prediction = 1'b0;
    bus.rob_valid      = 1'b0;
    bus.rob_pattern    = '0;
    bus.rob_addr       = '0;
    bus.rob_taken      = 1'b0;
    bus.rob_mispredict = 1'b0;
  endtask

  task automatic rob_drive(input logic v, input logic [1:0] pat, input logic [3:0] addr,
                           input logic tk, input logic mp);
    bus.rob_valid      = v;
    bus.rob_pattern    = pat;
    bus.rob_addr       = addr;
    bus.rob_taken      = tk;
    bus.rob_mispredict = mp;
  endtask

  task automatic dec_drive(input logic req, input logic [3:0] addr, input logic pred);
    bus.dec_req        = req;
    bus.dec_addr       = addr;
    bus.brp_prediction = pred;
  endtask

  logic [3:0] d_addr [8];
  logic       d_tk   [4];
  logic [3:0] e_addr [4];

  initial begin
    d_addr = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8};
    d_tk   = '{1'b1, 1'b1, 1'b0, 1'b1};
    e_addr = '{4'd4, 4'd5, 4'd6, 4'd7};
    idle_inputs();
    rst = 1'b1;

    // Reset
    @(negedge clk);
    @(negedge clk); #1;
    chk("rob_ready_in_rst", bus.rob_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_brp_update", bus.brp_update, 0);
    chk("rst_rob_ready", bus.rob_ready, 1);
    chk("rst_dec_pattern", bus.dec_pattern, 0);
    chk("rst_mp_cnt", bus.mispredict_cnt, 0);
    chk("rst_fifo_cnt", bus.dbg_fifo_cnt, 0);

    // Lookups, predictions 1,1,0
    @(negedge clk); dec_drive(1, 4'd5, 1); #1;
    chk("lk0_pattern", bus.dec_pattern, 2'b00);
    chk("lk0_brp_addr", bus.brp_addr, 5);
    chk("lk0_brp_pattern", bus.brp_pattern, 2'b00);
    chk("lk0_prediction", bus.dec_prediction, 1);
    @(negedge clk); dec_drive(1, 4'd6, 1); #1;
    chk("lk1_pattern", bus.dec_pattern, 2'b01);
    @(negedge clk); dec_drive(1, 4'd7, 0); #1;
    chk("lk2_pattern", bus.dec_pattern, 2'b11);
    chk("lk2_prediction", bus.dec_prediction, 0);
    @(negedge clk); dec_drive(0, 4'd0, 0); #1;
    chk("lk_final_ghr", bus.dec_pattern, 2'b10);

    // Three back-to-back commits with no lookups
    @(negedge clk); rob_drive(1, 2'd1, 4'd1, 1, 0); #1;
    chk("c1_ready", bus.rob_ready, 1);
    chk("c1_no_update", bus.brp_update, 0);
    @(negedge clk); rob_drive(1, 2'd2, 4'd2, 0, 0); #1;
    chk("c2_update", bus.brp_update, 1);
    chk("c2_upd_addr", bus.brp_upd_addr, 1);
    chk("c2_upd_taken", bus.brp_upd_taken, 1);
    chk("c2_upd_pattern", bus.brp_upd_pattern, 1);
    @(negedge clk); rob_drive(1, 2'd3, 4'd3, 1, 0); #1;
    chk("c3_update", bus.brp_update, 1);
    chk("c3_upd_addr", bus.brp_upd_addr, 2);
    chk("c3_upd_taken", bus.brp_upd_taken, 0);
    chk("c3_upd_pattern", bus.brp_upd_pattern, 2);
    @(negedge clk); rob_drive(0, 0, 0, 0, 0); #1;
    chk("c4_update", bus.brp_update, 1);
    chk("c4_upd_addr", bus.brp_upd_addr, 3);
    chk("c4_upd_taken", bus.brp_upd_taken, 1);
    chk("c4_commit_ghr", bus.dbg_commit_ghr, 2'b01);
    @(negedge clk); #1;
    chk("c5_update", bus.brp_update, 0);

    // Lookups hold the port while the ROB offers five commits
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      dec_drive(1, 4'd0, 0);
      rob_drive(d < 8, 2'd0, d_addr[d], (d < 4) ? d_tk[d] : 1'b0, 0);
      #1;
      chk($sformatf("d%0d_ready", d), bus.rob_ready, (d < 4) ? 1 : 0);
      chk($sformatf("d%0d_update", d), bus.brp_update, 0);
    end
    for (int e = 0; e < 5; e++) begin
      @(negedge clk);
      dec_drive(0, 4'd0, 0);
      rob_drive(0, 0, 0, 0, 0);
      #1;
      chk($sformatf("e%0d_update", e), bus.brp_update, (e < 4) ? 1 : 0);
      if (e < 4) chk($sformatf("e%0d_upd_addr", e), bus.brp_upd_addr, e_addr[e]);
      chk($sformatf("e%0d_ready", e), bus.rob_ready, (e == 0) ? 0 : 1);
    end
    chk("drain_commit_ghr", bus.dbg_commit_ghr, 2'b01);
    chk("drain_spec_ghr", bus.dec_pattern, 2'b00);

    // Bring spec_ghr to 11
    @(negedge clk); dec_drive(1, 4'd1, 1); #1;
    @(negedge clk); dec_drive(1, 4'd2, 1); #1;
    @(negedge clk); dec_drive(0, 4'd0, 0); #1;
    chk("pre_mp_spec_ghr", bus.dec_pattern, 2'b11);

    // Mispredict commit concurrent with a lookup
    @(negedge clk); dec_drive(1, 4'd3, 1); rob_drive(1, 2'd3, 4'd9, 0, 1); #1;
    chk("mp_prediction", bus.dec_prediction, 1);
    chk("mp_pattern", bus.dec_pattern, 2'b11);
    @(negedge clk); dec_drive(0, 4'd0, 0); rob_drive(0, 0, 0, 0, 0); #1;
    chk("mp_repaired_ghr", bus.dec_pattern, 2'b10);
    chk("mp_commit_ghr", bus.dbg_commit_ghr, 2'b10);
    chk("mp_cnt_1", bus.mispredict_cnt, 1);
    chk("mp_drain_addr", bus.brp_upd_addr, 9);
    chk("mp_drain_update", bus.brp_update, 1);

    // Fill three entries under lookup stall, then reset
    @(negedge clk); dec_drive(1, 4'd0, 0); rob_drive(1, 2'd1, 4'd10, 1, 0);
    @(negedge clk); rob_drive(1, 2'd1, 4'd11, 1, 0);
    @(negedge clk); rob_drive(1, 2'd1, 4'd12, 1, 0); #1;
    chk("fill_update_stalled", bus.brp_update, 0);
    @(negedge clk); dec_drive(0, 4'd0, 0); rob_drive(0, 0, 0, 0, 0); rst = 1'b1; #1;
    chk("fill_cnt_3", bus.dbg_fifo_cnt, 3);
    chk("rst2_update_in_rst", bus.brp_update, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst2_update", bus.brp_update, 0);
    chk("rst2_fifo_cnt", bus.dbg_fifo_cnt, 0);
    chk("rst2_spec_ghr", bus.dec_pattern, 0);
    chk("rst2_commit_ghr", bus.dbg_commit_ghr, 0);
    chk("rst2_mp_cnt", bus.mispredict_cnt, 0);
    chk("rst2_ready", bus.rob_ready, 1);
    @(negedge clk); #1;
    chk("rst2_update_later", bus.brp_update, 0);

    // Saturation of the mispredict counter
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      rob_drive(1, 2'd0, 4'(i), 1'(i), 1);
    end
    @(negedge clk); rob_drive(1, 2'd0, 4'd1, 0, 1); #1;
    chk("sat_fffe", bus.mispredict_cnt, 16'hFFFE);
    chk("sat_ready", bus.rob_ready, 1);
    @(negedge clk); #1;
    chk("sat_ffff_a", bus.mispredict_cnt, 16'hFFFF);
    @(negedge clk); #1;
    chk("sat_ffff_b", bus.mispredict_cnt, 16'hFFFF);
    @(negedge clk); rob_drive(0, 0, 0, 0, 0); #1;
    chk("sat_ffff_c", bus.mispredict_cnt, 16'hFFFF);
    @(negedge clk); #1;
    chk("sat_hold", bus.mispredict_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
